decode_stage: RTL

Instruction decode stage, directly downstream of instruction_register.
- Takes a fetched RV32I instruction word and its PC.
- Splits out the opcode and rd/rs1/rs2/funct fields.
- Generates the sign-extended immediate.
- Reads two operands from an internal 2-read/1-write register file with a write-back port.
- Presents the result in one output pipeline register, using valid/ready handshakes on both sides.

---
 rtl/cpu_pkg.sv | 84 ++++++++
 rtl/register_file.sv | 33 +++
 rtl/decode_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I decode types, opcodes and immediate helpers.
// Used by decode_stage (optional DECODE_STAGE_BYPASS_EN).
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } decoded_t;

  function automatic logic is_legal(input logic [31:0] inst);
    logic ok;
    ok = 1'b0;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BRANCH, OP_LOAD, OP_STORE,
        OP_IMM, OP_REG, OP_SYSTEM: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic imm_type_e imm_type(input logic [31:0] inst);
    imm_type_e t;
    t = IMM_NONE;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        OP_IMM, OP_LOAD,
        OP_JALR, OP_SYSTEM: t = IMM_I;
        OP_STORE:           t = IMM_S;
        OP_BRANCH:          t = IMM_B;
        OP_LUI, OP_AUIPC:   t = IMM_U;
        OP_JAL:             t = IMM_J;
        default:            t = IMM_NONE;
      endcase
    end
    return t;
  endfunction

  // Illegal and R-type opcodes both map to IMM_NONE, giving zero.
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] inst);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (imm_type(inst))
      IMM_I: imm = XLEN'($signed(inst[31:20]));
      IMM_S: imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      IMM_B: imm = XLEN'($signed({inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0}));
      IMM_U: imm = XLEN'($signed({inst[31:12], 12'b0}));
      IMM_J: imm = XLEN'($signed({inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// 2 async-read / 1 sync-write register file, x0 hardwired to 0.
// Used by decode_stage (optional DECODE_STAGE_BYPASS_EN).
module register_file #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: fields, immediate, operand read, output register.
// Optional same-cycle/stall forwarding under DECODE_STAGE_BYPASS_EN.
module decode_stage
  import cpu_pkg::*;
#(
  parameter  int XLEN     = cpu_pkg::XLEN,
  parameter  int NUM_REGS = 32,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_enable,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  decoded_t        d, q;
  logic            valid_q;
  logic            accept;
  logic [XLEN-1:0] rf_rs1, rf_rs2;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  register_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clock (clock),
    .reset (reset),
    .ra1   (in_instruction[15 +: RW]),
    .ra2   (in_instruction[20 +: RW]),
    .rd1   (rf_rs1),
    .rd2   (rf_rs2),
    .we    (wb_enable),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  always_comb begin
    d          = '0;
    d.pc       = in_pc;
    d.opcode   = in_instruction[6:0];
    d.rd       = in_instruction[11:7];
    d.rs1      = in_instruction[19:15];
    d.rs2      = in_instruction[24:20];
    d.funct3   = in_instruction[14:12];
    d.funct7   = in_instruction[31:25];
    d.rs1_data = rf_rs1;
    d.rs2_data = rf_rs2;
    d.imm      = imm_gen(in_instruction);
    d.illegal  = !is_legal(in_instruction);
`ifdef DECODE_STAGE_BYPASS_EN
    if (wb_enable && wb_rd == d.rs1[RW-1:0] && d.rs1 != '0)
      d.rs1_data = wb_data;
    if (wb_enable && wb_rd == d.rs2[RW-1:0] && d.rs2 != '0)
      d.rs2_data = wb_data;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q       <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      q       <= d;
      valid_q <= 1'b1;
    end else begin
      // in_ready without accept means in_valid is low: drain.
      if (in_ready)
        valid_q <= 1'b0;
`ifdef DECODE_STAGE_BYPASS_EN
      if (valid_q && !out_ready && wb_enable) begin
        if (wb_rd == q.rs1[RW-1:0] && q.rs1 != '0)
          q.rs1_data <= wb_data;
        if (wb_rd == q.rs2[RW-1:0] && q.rs2 != '0)
          q.rs2_data <= wb_data;
      end
`endif
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = q.pc;
  assign out_opcode   = q.opcode;
  assign out_rd       = q.rd;
  assign out_rs1      = q.rs1;
  assign out_rs2      = q.rs2;
  assign out_funct3   = q.funct3;
  assign out_funct7   = q.funct7;
  assign out_rs1_data = q.rs1_data;
  assign out_rs2_data = q.rs2_data;
  assign out_imm      = q.imm;
  assign out_illegal  = q.illegal;

endmodule
